// File: rtl/gpio_pinmux_ctrl.sv
// gpio_pinmux_ctrl: parametrised GPIO pin multiplexer with per-pin function
// select, software data/direction registers, a 2-flop input synchronizer and
// per-pin edge-detect interrupts, programmed over a simple register bus.
module gpio_pinmux_ctrl #(
  parameter int N_PINS = 16,
  parameter int FSEL_W = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic                                   rd_en,
  input  logic [3:0]                             addr,
  input  logic [N_PINS-1:0]                      wr_data,
  output logic [N_PINS-1:0]                      rd_data,
  input  logic [((2**FSEL_W)-1)*N_PINS-1:0]      periph_out,
  input  logic [((2**FSEL_W)-1)*N_PINS-1:0]      periph_oe,
  output logic [N_PINS-1:0]                      periph_in,
  input  logic [N_PINS-1:0]                      pad_in,
  output logic [N_PINS-1:0]                      pad_out,
  output logic [N_PINS-1:0]                      pad_oe,
  output logic                                   irq
);

  localparam int N_FUNC = 2 ** FSEL_W;

  localparam logic [3:0] ADDR_DATA_OUT = 4'd0;
  localparam logic [3:0] ADDR_DIR      = 4'd1;
  localparam logic [3:0] ADDR_PIN_IN   = 4'd2;
  localparam logic [3:0] ADDR_IRQ_EN   = 4'd3;
  localparam logic [3:0] ADDR_IRQ_STAT = 4'd4;
  localparam logic [3:0] ADDR_IRQ_MODE = 4'd5;

  // Software-visible registers
  logic [N_PINS-1:0] data_out_q;
  logic [N_PINS-1:0] dir_q;
  logic [N_PINS-1:0] irq_en_q;
  logic [N_PINS-1:0] irq_stat_q;
  logic [N_PINS-1:0] irq_mode_q;

  // Input path: two synchronizer stages plus one history flop for edges
  logic [N_PINS-1:0] sync1_q;
  logic [N_PINS-1:0] sync2_q;
  logic [N_PINS-1:0] prev_q;

  // FSEL planes padded out to four so the read mux can index with addr[1:0];
  // planes beyond FSEL_W have no storage and read as zero.
  logic [3:0][N_PINS-1:0] fsel_view;

  // Per-pin function select assembled from the planes
  logic [N_PINS-1:0][FSEL_W-1:0] sel;

  // Function tables: entry 0 is software GPIO, entries 1.. are peripherals
  logic [N_FUNC-1:0][N_PINS-1:0] func_out;
  logic [N_FUNC-1:0][N_PINS-1:0] func_oe;

  logic [N_PINS-1:0] pad_out_d;
  logic [N_PINS-1:0] pad_oe_d;
  logic [N_PINS-1:0] rd_mux;
  logic [N_PINS-1:0] w1c;
  logic [N_PINS-1:0] edge_v;

  genvar k, i, f;

  generate
    for (k = 0; k < 4; k++) begin : g_plane
      if (k < FSEL_W) begin : g_used
        logic [N_PINS-1:0] plane_q;

        // One FSEL plane register, written at address 8+k
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            plane_q <= '0;
          end else if (wr_en && (addr == 4'(8 + k))) begin
            plane_q <= wr_data;
          end
        end

        assign fsel_view[k] = plane_q;
      end else begin : g_unused
        assign fsel_view[k] = '0;
      end
    end

    for (i = 0; i < N_PINS; i++) begin : g_sel_pin
      for (k = 0; k < FSEL_W; k++) begin : g_sel_bit
        assign sel[i][k] = fsel_view[k][i];
      end
    end

    assign func_out[0] = data_out_q;
    assign func_oe[0]  = dir_q;
    for (f = 1; f < N_FUNC; f++) begin : g_func
      assign func_out[f] = periph_out[(f-1)*N_PINS +: N_PINS];
      assign func_oe[f]  = periph_oe[(f-1)*N_PINS +: N_PINS];
    end

    for (i = 0; i < N_PINS; i++) begin : g_mux
      assign pad_out_d[i] = func_out[sel[i]][i];
      assign pad_oe_d[i]  = func_oe[sel[i]][i];
    end
  endgenerate

  // Edge selection per pin: IRQ_MODE picks falling (1) or rising (0)
  assign edge_v = (irq_mode_q & ~sync2_q & prev_q) | (~irq_mode_q & sync2_q & ~prev_q);

  // Write-1-to-clear mask for IRQ_STAT
  assign w1c = (wr_en && (addr == ADDR_IRQ_STAT)) ? wr_data : '0;

  assign periph_in = sync2_q;
  assign irq       = |irq_stat_q;

  // Read mux over the register map; unmapped addresses return zero
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DATA_OUT: rd_mux = data_out_q;
      ADDR_DIR:      rd_mux = dir_q;
      ADDR_PIN_IN:   rd_mux = sync2_q;
      ADDR_IRQ_EN:   rd_mux = irq_en_q;
      ADDR_IRQ_STAT: rd_mux = irq_stat_q;
      ADDR_IRQ_MODE: rd_mux = irq_mode_q;
      4'd8, 4'd9, 4'd10, 4'd11: rd_mux = fsel_view[addr[1:0]];
      default:       rd_mux = '0;
    endcase
  end

  // Register file, input synchronizer, status update and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_mode_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      rd_data    <= '0;
      pad_out    <= '0;
      pad_oe     <= '0;
    end else begin
      if (wr_en) begin
        case (addr)
          ADDR_DATA_OUT: data_out_q <= wr_data;
          ADDR_DIR:      dir_q      <= wr_data;
          ADDR_IRQ_EN:   irq_en_q   <= wr_data;
          ADDR_IRQ_MODE: irq_mode_q <= wr_data;
          default: ;
        endcase
      end
      irq_stat_q <= (irq_stat_q & ~w1c) | (irq_en_q & edge_v);
      sync1_q    <= pad_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      if (rd_en) begin
        rd_data <= rd_mux;
      end
      pad_out <= pad_out_d;
      pad_oe  <= pad_oe_d;
    end
  end

endmodule

// File: doc/gpio_pinmux_ctrl.md
Name: gpio_pinmux_ctrl

Overview:
Parametrised GPIO pin-multiplexer controller. It is the successor to the fixed 16-pin enable-based pin mux.
- Each pin gets an independent N-way function select, direction control, and a software data register.
- Pad inputs pass through a 2-flop synchronizer, with edge-detect interrupts per pin.
- Sits between the peripheral cluster (UART/SPI/I2C/PWM/timer) and the pad ring; programmed over a simple register bus.

Parameters:
N_PINS, 16, number of pads handled.
FSEL_W, 2, function-select width per pin (1..4); N_FUNC = 2**FSEL_W functions per pin, function 0 = software GPIO.

Ports:
clk  in  1  single system clock, all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
wr_en  in  1  register write strobe.
rd_en  in  1  register read strobe.
addr  in  4  register address.
wr_data  in  N_PINS  write data.
rd_data  out  N_PINS  read data, registered.
periph_out  in  (N_FUNC-1)*N_PINS  peripheral output values; function f (f>=1) for pin i is bit (f-1)*N_PINS+i.
periph_oe  in  (N_FUNC-1)*N_PINS  peripheral output enables, same indexing.
periph_in  out  N_PINS  synchronized pad values broadcast to peripherals.
pad_in  in  N_PINS  asynchronous pad inputs.
pad_out  out  N_PINS  pad output values, registered.
pad_oe  out  N_PINS  pad output enables, registered, 1 = drive.
irq  out  1  OR of IRQ_STAT.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset state: every register, both synchronizer stages, the edge-history flop, rd_data, pad_out and pad_oe are cleared to 0; irq = 0.
- Register map (N_PINS bits each):
  - 0 DATA_OUT (rw)
  - 1 DIR (rw, 1 = output)
  - 2 PIN_IN (ro, sync stage-2 value)
  - 3 IRQ_EN (rw)
  - 4 IRQ_STAT (read; write-1-to-clear)
  - 5 IRQ_MODE (rw, 0 = rising, 1 = falling)
  - 8+k FSEL plane k (rw, bit i = select bit k of pin i), for k < FSEL_W
  - all other addresses read 0; writes to them are ignored
- Writes: take effect on the clock edge with wr_en = 1. Writes to PIN_IN are ignored.
- Reads: rd_data is updated on the edge with rd_en = 1 (1-cycle latency) and holds otherwise. A read and write to the same address in one cycle returns the pre-write value.
- Pad mux: sel_i = {FSEL planes}[i].
  - sel_i = 0: pad_out = DATA_OUT[i], pad_oe = DIR[i].
  - sel_i >= 1: pad_out = periph_out[(sel_i-1)*N_PINS+i], pad_oe = periph_oe[same index].
  - pad_out/pad_oe are registered, so a change on registers or periph_* is visible 1 cycle later.
- Input path: sync1 <= pad_in, sync2 <= sync1, prev <= sync2; periph_in = sync2.
- Edge detect: rise_i = sync2 & ~prev, fall_i = ~sync2 & prev, edge_i = IRQ_MODE[i] ? fall_i : rise_i.
  - A pad transition sets IRQ_STAT on the 3rd rising clk edge after it is first sampled.
- IRQ_STAT[i] next value = (IRQ_STAT[i] & ~(W1C hit on bit i)) | (IRQ_EN[i] & edge_i). A set in the same cycle as a clear wins.
- Changing IRQ_EN or IRQ_MODE never clears IRQ_STAT; disabling only blocks new sets.
- irq = |IRQ_STAT, combinational from flops (no extra latency).
- Pulses shorter than one clk period may be missed; no glitch filtering.
- Reset asserted mid-operation: all state returns to reset values on that edge; pending status is lost.

Test Plan:
- Reset, then read every address -> rd_data = 0 one cycle after each rd_en; pad_oe = 0, irq = 0.
- Write DIR = 0x00FF, DATA_OUT = 0x00A5 with sel = 0 -> next cycle pad_oe = 0x00FF, pad_out = 0x00A5.
- Pin 3: write plane0 bit3 = 1 (sel = 1), drive periph_out[3] = 1, periph_oe[3] = 1 -> pad_out[3] = 1, pad_oe[3] = 1 one cycle later, DATA_OUT ignored. With sel = 3: output follows periph_out[2*N_PINS+3].
- IRQ_EN = 0x0001, IRQ_MODE = 0: raise pad_in[0] -> IRQ_STAT = 0x0001 and irq = 1 on the 3rd edge. Falling edge adds nothing. Write 1 to addr 4 bit0 -> irq = 0 next cycle.
- Rising edge arriving in the same cycle as its W1C -> IRQ_STAT bit stays 1. With IRQ_EN bit clear, an edge leaves IRQ_STAT = 0.
- Assert rst_n = 0 for one cycle while irq = 1 and pads driven -> all outputs 0 on that edge.
